// File: rtl/ram_copy_dma.sv
// ram_copy_dma: single-master word copier, one RAM read then one RAM write per word.
// Define RAM_COPY_CHECKSUM_EN to add the running checksum output SUM.
module ram_copy_dma #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 10
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic [ADDR_W-1:0] SRC,
  input  logic [ADDR_W-1:0] DST,
  input  logic [ADDR_W:0]   LEN,
  output logic              BUSY,
  output logic              DONE,
  output logic              MEM_WE,
  output logic [WIDTH-1:0]  MEM_ADDRESS,
  output logic [WIDTH-1:0]  MEM_WD,
`ifdef RAM_COPY_CHECKSUM_EN
  output logic [WIDTH-1:0]  SUM,
`endif
  input  logic [WIDTH-1:0]  MEM_RD
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_DONE
  } state_t;

  localparam logic [ADDR_W-1:0] A_ONE = 1;
  localparam logic [ADDR_W:0]   L_ONE = 1;

  state_t            state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   rem_q;

  assign MEM_ADDRESS = {{(WIDTH-ADDR_W){1'b0}}, addr_q};

  // Copy sequencer: all RAM-facing outputs are registered here.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= S_IDLE;
      src_q  <= '0;
      dst_q  <= '0;
      addr_q <= '0;
      rem_q  <= '0;
      BUSY   <= 1'b0;
      DONE   <= 1'b0;
      MEM_WE <= 1'b0;
      MEM_WD <= '0;
`ifdef RAM_COPY_CHECKSUM_EN
      SUM    <= '0;
`endif
    end else begin
      unique case (state)
        S_IDLE: begin
          if (START) begin
            BUSY <= 1'b1;
`ifdef RAM_COPY_CHECKSUM_EN
            SUM  <= '0;
`endif
            if (LEN == '0) begin
              state <= S_DONE;
              DONE  <= 1'b1;
            end else begin
              state  <= S_READ;
              addr_q <= SRC;
              src_q  <= SRC + A_ONE;
              dst_q  <= DST;
              rem_q  <= LEN;
            end
          end
        end
        S_READ: begin
          state  <= S_WRITE;
          MEM_WE <= 1'b1;
          MEM_WD <= MEM_RD;
          addr_q <= dst_q;
          dst_q  <= dst_q + A_ONE;
          rem_q  <= rem_q - L_ONE;
        end
        S_WRITE: begin
          MEM_WE <= 1'b0;
`ifdef RAM_COPY_CHECKSUM_EN
          SUM    <= SUM + MEM_WD;
`endif
          if (rem_q != '0) begin
            state  <= S_READ;
            addr_q <= src_q;
            src_q  <= src_q + A_ONE;
          end else begin
            state <= S_DONE;
            DONE  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          DONE  <= 1'b0;
          BUSY  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_copy_dma.sv
// tb_ram_copy_dma: directed and random copies against a forward-loop memory model.
// Build with RAM_COPY_CHECKSUM_EN defined to also check SUM.
module tb_ram_copy_dma;

  localparam int N = 1024;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic [9:0]  SRC;
  logic [9:0]  DST;
  logic [10:0] LEN;
  logic        BUSY;
  logic        DONE;
  logic        MEM_WE;
  logic [31:0] MEM_ADDRESS;
  logic [31:0] MEM_WD;
  logic [31:0] MEM_RD;
`ifdef RAM_COPY_CHECKSUM_EN
  logic [31:0] SUM;
`endif

  logic [31:0] ram  [N];
  logic [31:0] gold [N];
  logic        preload;

  int vectors = 0;
  int miscompares = 0;

  ram_copy_dma #(.WIDTH(32), .ADDR_W(10)) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .START(START),
    .SRC(SRC),
    .DST(DST),
    .LEN(LEN),
    .BUSY(BUSY),
    .DONE(DONE),
    .MEM_WE(MEM_WE),
    .MEM_ADDRESS(MEM_ADDRESS),
    .MEM_WD(MEM_WD),
`ifdef RAM_COPY_CHECKSUM_EN
    .SUM(SUM),
`endif
    .MEM_RD(MEM_RD)
  );

  always #5 CLK = ~CLK;

  assign MEM_RD = ram[MEM_ADDRESS[9:0]];

  // RAM: preload image RAM[i]=i, otherwise synchronous write
  always @(posedge CLK) begin
    if (preload) begin
      for (int i = 0; i < N; i++) ram[i] <= 32'(i);
    end else if (MEM_WE) begin
      ram[MEM_ADDRESS[9:0]] <= MEM_WD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_preload();
    @(negedge CLK);
    preload = 1'b1;
    @(negedge CLK);
    preload = 1'b0;
    for (int i = 0; i < N; i++) gold[i] = 32'(i);
  endtask

  task automatic chk_image();
    int diffs = 0;
    for (int i = 0; i < N; i++)
      if (ram[i] !== gold[i]) diffs++;
    chk("ram_image", diffs, 0);
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, 32'(BUSY), 0);
    chk({tag, "_done"}, 32'(DONE), 0);
    chk({tag, "_we"}, 32'(MEM_WE), 0);
  endtask

  // mode: 0 plain, 1 START pulse mid-copy, 2 START held in DONE cycle
  task automatic run_copy(input int src, input int dst, input int len,
                          input int mode, input int rst_cyc);
    logic [31:0] wd [$];
    logic [31:0] esum;
    int last;
    int i;
    esum = 0;
    for (int k = 0; k < len; k++) begin
      wd.push_back(gold[(src + k) % N]);
      esum += gold[(src + k) % N];
      if (rst_cyc == 0 || 2 + 2 * k < rst_cyc)
        gold[(dst + k) % N] = wd[k];
    end
    last = 2 * len + 3;
    @(negedge CLK);
    SRC   = 10'(src);
    DST   = 10'(dst);
    LEN   = 11'(len);
    START = 1'b1;
    for (int cyc = 1; cyc <= last; cyc++) begin
      @(negedge CLK);
      if (cyc == rst_cyc) begin
        RST_N = 1'b0;
        #1;
        chk_quiet("rst_abort");
        chk("rst_addr", MEM_ADDRESS, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        START = 1'b0;
        for (int q = 0; q < 3; q++) begin
          @(negedge CLK);
          chk_quiet("post_rst");
        end
        break;
      end
      chk("busy", 32'(BUSY), 32'(cyc <= 2 * len + 1));
      chk("done", 32'(DONE), 32'(cyc == 2 * len + 1));
      chk("we", 32'(MEM_WE), 32'(cyc % 2 == 0 && cyc <= 2 * len));
      if (cyc <= 2 * len) begin
        i = (cyc - 1) / 2;
        if (cyc % 2 == 1) begin
          chk("rd_addr", MEM_ADDRESS, 32'((src + i) % N));
        end else begin
          chk("wr_addr", MEM_ADDRESS, 32'((dst + i) % N));
          chk("wr_data", MEM_WD, wd[i]);
        end
      end
`ifdef RAM_COPY_CHECKSUM_EN
      if (cyc == 2 * len + 1) chk("sum", SUM, esum);
`endif
      if (cyc == 1) begin
        START = 1'b0;
        SRC   = 10'($urandom);
        DST   = 10'($urandom);
        LEN   = 11'($urandom_range(1, 8));
      end
      if (mode == 1 && cyc == 3) begin
        START = 1'b1;
        SRC   = 10'd5;
      end
      if (mode == 1 && cyc == 4) START = 1'b0;
      if (mode == 2 && cyc == 2 * len + 1) START = 1'b1;
      if (mode == 2 && cyc == 2 * len + 2) START = 1'b0;
    end
    chk_image();
  endtask

  initial begin
    int s, d, l;
    RST_N   = 1'b0;
    START   = 1'b0;
    SRC     = '0;
    DST     = '0;
    LEN     = '0;
    preload = 1'b1;
    for (int i = 0; i < N; i++) gold[i] = 32'(i);
    repeat (3) @(negedge CLK);
    preload = 1'b0;

    // test 1: reset state, then idle
    chk_quiet("reset");
    chk("reset_addr", MEM_ADDRESS, 0);
    chk("reset_wd", MEM_WD, 0);
`ifdef RAM_COPY_CHECKSUM_EN
    chk("reset_sum", SUM, 0);
`endif
    RST_N = 1'b1;
    for (int q = 0; q < 5; q++) begin
      @(negedge CLK);
      chk_quiet("idle");
    end

    // test 2: basic copy
    run_copy(0, 100, 4, 0, 0);
    // test 6a: START while busy ignored
    do_preload();
    run_copy(0, 100, 4, 1, 0);
    // test 3: zero length
    do_preload();
    run_copy(7, 200, 0, 0, 0);
    // test 4: forward overlap
    run_copy(10, 11, 3, 0, 0);
    // test 5: address wrap
    run_copy(1022, 500, 4, 0, 0);
    // test 6b: reset in cycle 5
    do_preload();
    run_copy(0, 100, 4, 0, 5);
    // START in DONE cycle ignored
    run_copy(300, 40, 2, 2, 0);

    // randomized copies
    for (int r = 0; r < 8; r++) begin
      s = $urandom_range(0, N - 1);
      d = $urandom_range(0, N - 1);
      l = $urandom_range(0, 24);
      if (r == 0) s = 1020;
      run_copy(s, d, l, 0, 0);
    end

    // full-space copy with overlap
    do_preload();
    run_copy(0, 512, N, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
